wfg_record_spi: RTL

// - SPI slave receiver: the capture counterpart of the SPI drive block. It samples external sclk, cs_n and sdi.
// - Assembles 8/16/24/32-bit words and emits them on an AXI-Stream master port into the wfg stream fabric.
// - tlast marks the final complete word of each chip-select frame.
// - Sits behind the same wishbone register block style as the drive core; all cfg inputs come from register q outputs.

---
 rtl/wfg_record_spi_pkg.sv | 27 ++
 rtl/wfg_record_spi_sync.sv | 24 ++
 rtl/wfg_record_spi.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wfg_record_spi_pkg.sv
// Shared types and helpers for the SPI record (receive) block.
package wfg_record_spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rec_state_t;

    // Word length encoding of cfg_dff_q_i
    localparam logic [1:0] DFF_8  = 2'b00;
    localparam logic [1:0] DFF_16 = 2'b01;
    localparam logic [1:0] DFF_24 = 2'b10;
    localparam logic [1:0] DFF_32 = 2'b11;

    // Number of bits per word for a given dff setting
    function automatic logic [5:0] dff_bits(input logic [1:0] dff);
        logic [5:0] n;
        case (dff)
            DFF_8:   n = 6'd8;
            DFF_16:  n = 6'd16;
            DFF_24:  n = 6'd24;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wfg_record_spi_sync.sv
// Two-flop synchroniser for one asynchronous input plus a delay stage,
// giving the synchronised level and single-cycle rise/fall pulses.
module wfg_record_spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] r_pipe;

    // [0],[1] resolve metastability; [2] is the previous synchronised value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= 3'b000;
        else        r_pipe <= {r_pipe[1:0], i_async};
    end

    assign o_level = r_pipe[1];
    assign o_rise  = r_pipe[1] & ~r_pipe[2];
    assign o_fall  = ~r_pipe[1] & r_pipe[2];

endmodule

// File: rtl/wfg_record_spi.sv
// SPI slave receiver: assembles 8/16/24/32-bit words from an external SPI
// master and presents them on an AXI-Stream master port with tlast on the
// final complete word of each chip-select frame.
module wfg_record_spi #(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_cpha_q_i,
    input  logic                       cfg_cpol_q_i,
    input  logic                       cfg_lsbfirst_q_i,
    input  logic [1:0]                 cfg_dff_q_i,
    input  logic                       cfg_sspol_q_i,
    input  logic                       wfg_record_spi_sclk_i,
    input  logic                       wfg_record_spi_cs_ni,
    input  logic                       wfg_record_spi_sdi_i,
    output logic                       wfg_axis_tvalid_o,
    input  logic                       wfg_axis_tready_i,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    output logic                       wfg_axis_tlast_o,
    output logic                       sts_ovr_o
);
    import wfg_record_spi_pkg::*;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sdi, w_sdi_rise_unused, w_sdi_fall_unused;

    wfg_record_spi_sync u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(wfg_record_spi_sclk_i),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    wfg_record_spi_sync u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(wfg_record_spi_cs_ni),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    wfg_record_spi_sync u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .i_async(wfg_record_spi_sdi_i),
        .o_level(w_sdi), .o_rise(w_sdi_rise_unused), .o_fall(w_sdi_fall_unused)
    );

    rec_state_t                 r_state;
    logic [31:0]                r_shift;
    logic [4:0]                 r_cnt;
    logic [31:0]                r_pend;
    logic                       r_pend_v;
    logic                       r_tvalid;
    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic                       r_tlast;
    logic                       r_ovr;

    logic        w_sample, w_cs_act, w_cs_act_rise, w_word_done, w_hs;
    logic        w_push, w_push_last;
    logic [31:0] w_shift_nxt;

    // Edge classification, next shift value and push decision
    always_comb begin
        // Sampling edge: new sclk level is 1 (rising) when cpol==cpha, else 0
        w_sample      = (w_sclk_rise | w_sclk_fall) &
                        (w_sclk_lvl == (cfg_cpol_q_i ~^ cfg_cpha_q_i));
        w_cs_act      = w_cs_lvl ^ ~cfg_sspol_q_i;
        // Active-high cs asserts on pin rise, active-low on pin fall
        w_cs_act_rise = cfg_sspol_q_i ? w_cs_rise : w_cs_fall;
        w_word_done   = ({1'b0, r_cnt} == dff_bits(cfg_dff_q_i) - 6'd1);
        w_hs          = r_tvalid & wfg_axis_tready_i;

        w_shift_nxt = r_shift;
        if (cfg_lsbfirst_q_i) w_shift_nxt[r_cnt] = w_sdi;
        else                  w_shift_nxt = {r_shift[30:0], w_sdi};

        // The pending word is released only when the next word completes
        // (tlast=0) or the frame ends (tlast=1), so a trailing partial word
        // can never leave the last complete word without tlast.
        w_push      = 1'b0;
        w_push_last = 1'b0;
        if (ctrl_en_q_i && (r_state == SHIFT) && r_pend_v) begin
            if (!w_cs_act) begin
                w_push      = 1'b1;
                w_push_last = 1'b1;
            end else if (w_sample && w_word_done) begin
                w_push      = 1'b1;
            end
        end
    end

    // Receive FSM, pending stage and AXIS output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_push) begin
                if (!r_tvalid || w_hs) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= AXIS_DATA_WIDTH'(r_pend);
                    r_tlast  <= w_push_last;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end

            if (!ctrl_en_q_i) begin
                // Output register is left alone so a waiting word is not lost
                r_state  <= IDLE;
                r_shift  <= '0;
                r_cnt    <= '0;
                r_pend   <= '0;
                r_pend_v <= 1'b0;
                r_ovr    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_act_rise) begin
                            r_state <= SHIFT;
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    SHIFT: begin
                        if (!w_cs_act) begin
                            // Partial word is discarded; pend was pushed above
                            r_state  <= IDLE;
                            r_shift  <= '0;
                            r_cnt    <= '0;
                            r_pend_v <= 1'b0;
                        end else if (w_sample) begin
                            if (w_word_done) begin
                                r_pend   <= w_shift_nxt;
                                r_pend_v <= 1'b1;
                                r_shift  <= '0;
                                r_cnt    <= '0;
                            end else begin
                                r_shift <= w_shift_nxt;
                                r_cnt   <= r_cnt + 5'd1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign wfg_axis_tvalid_o = r_tvalid;
    assign wfg_axis_tdata_o  = r_tdata;
    assign wfg_axis_tlast_o  = r_tlast;
    assign sts_ovr_o         = r_ovr;

endmodule
